// File: rtl/alu_pkg.sv
// Shared ALU types: result flags, per-beat control carried down the pipe,
// and signed max/min pattern helpers.
package alu_pkg;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic negative;
    } flags_t;

    // 'signed' is a keyword, hence is_signed.
    typedef struct packed {
        logic sub;
        logic is_signed;
        logic sat;
    } ctrl_t;

    localparam int ALU_MAX_W = 64;

    // 011...1 in the low w bits.
    function automatic logic [ALU_MAX_W-1:0] signed_max(input int w);
        return {ALU_MAX_W{1'b1}} >> (ALU_MAX_W - w + 1);
    endfunction

    // 100...0 in the low w bits.
    function automatic logic [ALU_MAX_W-1:0] signed_min(input int w);
        return {{(ALU_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    endfunction

endpackage

// File: rtl/add_sub_stage.sv
// One CHUNK-bit slice of the carry-pipelined adder: adds a, b and cin,
// registering the sum chunk and carry-out when the pipe advances.
module add_sub_stage #(
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum_q,
    output logic             cout_q
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (en) begin
            {cout_q, sum_q} <= total;
        end
    end

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor, CHUNK bits of carry per stage, with
// zero/overflow/negative flags. Define ADDSUB_SATURATE_EN to enable clamping.
module add_sub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_signed,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_negative
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    // Handshake: a beat moves on a cycle where valid & ready are both high.
    // The whole pipe (bubbles included) shifts whenever the output slot is
    // empty or being consumed, so in_ready is exactly that advance condition.
    logic adv;

    logic             v_in    [STAGES];
    ctrl_t            ctrl_in [STAGES];
    logic [WIDTH-1:0] a_in    [STAGES];
    logic [WIDTH-1:0] b_in    [STAGES];
    logic [WIDTH-1:0] lo_in   [STAGES];
    logic             cin     [STAGES];

    logic             v_q     [STAGES];
    ctrl_t            ctrl_q  [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] lo_q    [STAGES];
    logic [CHUNK-1:0] sum_q   [STAGES];
    logic             cout_q  [STAGES];

    assign adv      = ~v_q[LAST] | out_ready;
    assign in_ready = adv;

    // Stage inputs: b is pre-inverted for subtraction, with carry-in = sub.
    // lo_in collects the already-resolved low chunks of the same beat.
    always_comb begin
        v_in[0]          = in_valid & adv;
        ctrl_in[0].sub       = in_sub;
        ctrl_in[0].is_signed = in_signed;
        ctrl_in[0].sat       = in_sat;
        a_in[0]          = in_a;
        b_in[0]          = in_b ^ {WIDTH{in_sub}};
        lo_in[0]         = '0;
        cin[0]           = in_sub;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k]    = v_q[k-1];
            ctrl_in[k] = ctrl_q[k-1];
            a_in[k]    = a_q[k-1];
            b_in[k]    = b_q[k-1];
            cin[k]     = cout_q[k-1];
            lo_in[k]   = lo_q[k-1];
            lo_in[k][(k-1)*CHUNK +: CHUNK] = sum_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]    <= 1'b0;
                ctrl_q[k] <= '0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                lo_q[k]   <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]    <= v_in[k];
                ctrl_q[k] <= ctrl_in[k];
                a_q[k]    <= a_in[k];
                b_q[k]    <= b_in[k];
                lo_q[k]   <= lo_in[k];
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        add_sub_stage #(.CHUNK(CHUNK)) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (adv),
            .a      (a_in[g][g*CHUNK +: CHUNK]),
            .b      (b_in[g][g*CHUNK +: CHUNK]),
            .cin    (cin[g]),
            .sum_q  (sum_q[g]),
            .cout_q (cout_q[g])
        );
    end

    // Final stage: assemble the wrapped sum and derive flags from it.
    logic [WIDTH-1:0] s_wrap;
    logic             a_msb, b_msb, s_msb, carry;
    ctrl_t            ctrl_l;
    flags_t           fl;

    always_comb begin
        s_wrap = lo_q[LAST];
        s_wrap[LAST*CHUNK +: CHUNK] = sum_q[LAST];
        ctrl_l = ctrl_q[LAST];
        carry  = cout_q[LAST];
        a_msb  = a_q[LAST][WIDTH-1];
        b_msb  = b_q[LAST][WIDTH-1] ^ ctrl_l.sub;
        s_msb  = s_wrap[WIDTH-1];
        fl     = '0;
        case ({ctrl_l.is_signed, ctrl_l.sub})
            2'b10: begin
                fl.overflow = (a_msb == b_msb) & (s_msb != a_msb);
                fl.negative = (a_msb != b_msb) ? s_msb : a_msb;
            end
            2'b11: begin
                fl.overflow = (a_msb != b_msb) & (s_msb != a_msb);
                fl.negative = (a_msb == b_msb) ? s_msb : a_msb;
            end
            2'b00: begin
                fl.overflow = carry;
                fl.negative = 1'b0;
            end
            default: begin
                fl.overflow = ~carry;
                fl.negative = ~carry;
            end
        endcase
        fl.zero = (s_wrap == '0) & ~fl.overflow;
    end

    assign out_valid    = v_q[LAST];
    assign out_zero     = v_q[LAST] & fl.zero;
    assign out_overflow = v_q[LAST] & fl.overflow;
    assign out_negative = v_q[LAST] & fl.negative;

`ifdef ADDSUB_SATURATE_EN
    localparam logic [ALU_MAX_W-1:0] SMAX_FULL = signed_max(WIDTH);
    localparam logic [ALU_MAX_W-1:0] SMIN_FULL = signed_min(WIDTH);
    localparam logic [WIDTH-1:0]     S_MAX     = SMAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     S_MIN     = SMIN_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] sat_val;

    always_comb begin
        if (ctrl_l.is_signed) sat_val = fl.negative ? S_MIN : S_MAX;
        else                  sat_val = ctrl_l.sub ? '0 : '1;
        out_s = (ctrl_l.sat & fl.overflow) ? sat_val : s_wrap;
    end
`else
    assign out_s = s_wrap;
`endif

endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe (WIDTH=32, CHUNK=8): directed vectors,
// stall burst, latency and asynchronous mid-stream reset.
module tb_add_sub_pipe;

    localparam int W = 32;

`ifdef ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic         in_signed = 1'b0;
    logic         in_sat = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_s;
    logic         out_zero, out_overflow, out_negative;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit push_en = 1'b1;
    logic [W+2:0] exp_q[$];

    add_sub_pipe #(.WIDTH(W), .CHUNK(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .in_signed    (in_signed),
        .in_sat       (in_sat),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_s        (out_s),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_negative (out_negative)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    function automatic logic [W+2:0] e(input logic [W-1:0] s, input logic z, o, n);
        return {s, z, o, n};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: called at posedge+2, returns at posedge+2 with in_valid low
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                        input bit sgn, input bit sat, input logic [W+2:0] exp, output int acc);
        int n;
        n = 0;
        in_a = a; in_b = b; in_sub = sub; in_signed = sgn; in_sat = sat; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end else if (push_en) begin
            exp_q.push_back(exp);
        end
        acc = cyc;
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // monitor / scoreboard
    initial begin
        logic [W+2:0] held, got;
        bit holding;
        holding = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            got = {out_s, out_zero, out_overflow, out_negative};
            if (!rst_n) begin
                holding = 1'b0;
            end else begin
                if (holding) check("stall_hold", got, held);
                holding = out_valid && !out_ready;
                held = got;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_out: got %h expected no output", got);
                    end else begin
                        check("result", got, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        int acc, n, sent;
        repeat (3) @(negedge clk);
        check("reset_out", {out_valid, out_s, out_zero, out_overflow, out_negative}, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);
        @(posedge clk); #2;

        // latency on the first beat
        send(32'h7FFFFFFF, 32'h00000001, 0, 1, 0, e(32'h80000000, 0, 1, 0), acc);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("latency", cyc - acc, 4);
        @(posedge clk); #2;

        send(32'h00000003, 32'h00000005, 1, 0, 0, e(32'hFFFFFFFE, 0, 1, 1), acc);
        send(32'h00000003, 32'h00000005, 1, 0, 1, e(SAT ? 32'h00000000 : 32'hFFFFFFFE, 0, 1, 1), acc);
        send(32'h80000000, 32'h00000001, 1, 1, 0, e(32'h7FFFFFFF, 0, 1, 1), acc);
        send(32'h80000000, 32'h00000001, 1, 1, 1, e(SAT ? 32'h80000000 : 32'h7FFFFFFF, 0, 1, 1), acc);
        send(32'hFFFFFFFF, 32'h00000001, 0, 0, 0, e(32'h00000000, 0, 1, 0), acc);
        send(32'hFFFFFFFB, 32'h00000005, 0, 1, 0, e(32'h00000000, 1, 0, 0), acc);
        send(32'h00000005, 32'h00000005, 1, 0, 0, e(32'h00000000, 1, 0, 0), acc);
        send(32'hFFFFFFFE, 32'h00000003, 1, 1, 0, e(32'hFFFFFFFB, 0, 0, 1), acc);
        send(32'h7FFFFFFF, 32'h7FFFFFFF, 0, 1, 1, e(SAT ? 32'h7FFFFFFF : 32'hFFFFFFFE, 0, 1, 0), acc);
        send(32'h80000000, 32'h80000000, 0, 0, 1, e(SAT ? 32'hFFFFFFFF : 32'h00000000, 0, 1, 0), acc);
        send(32'h00000100, 32'h00000001, 1, 1, 0, e(32'h000000FF, 0, 0, 0), acc);
        send(32'h00001234, 32'h00000001, 0, 0, 0, e(32'h00001235, 0, 0, 0), acc);
        drain();

        // back-to-back burst with out_ready low in cycles 6..9
        @(posedge clk); #2;
        sent = 0;
        for (int i = 0; i < 40; i++) begin
            out_ready = !(i >= 6 && i <= 9);
            if (sent < 20) begin
                in_valid = 1'b1; in_a = 32'h10000000 + sent; in_b = sent;
                in_sub = 1'b0; in_signed = 1'b0; in_sat = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 30) check("in_ready_stall", in_ready, (i >= 6 && i <= 9) ? 0 : 1);
            if (in_valid && in_ready) begin
                exp_q.push_back(e(32'h10000000 + 2 * sent, 0, 0, 0));
                sent++;
            end
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("burst_count", sent, 20);
        drain();

        // asynchronous reset with three beats in flight
        @(posedge clk); #2;
        push_en = 1'b0;
        send(32'h00000001, 32'h00000001, 0, 0, 0, e(32'h00000002, 0, 0, 0), acc);
        send(32'h00000002, 32'h00000002, 0, 0, 0, e(32'h00000004, 0, 0, 0), acc);
        send(32'h00000003, 32'h00000003, 0, 0, 0, e(32'h00000006, 0, 0, 0), acc);
        rst_n = 1'b0;
        #1;
        check("midreset_out", {out_valid, out_s, out_zero, out_overflow, out_negative}, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        push_en = 1'b1;
        @(negedge clk);
        check("ready_after_midreset", in_ready, 1);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("no_stale", n, 0);

        @(posedge clk); #2;
        send(32'h0000000A, 32'h00000003, 1, 0, 0, e(32'h00000007, 0, 0, 0), acc);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
